// File: rtl/machine_state_dumper_if.sv
// Dump-side bus of the state dumper: halt input, regfile and data-memory read
// ports, the valid/ready output stream and the busy/done status flags.
interface machine_state_dumper_if;
  logic        halt;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [29:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_kind;
  logic [29:0] out_index;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  // Dumper side
  modport master (
    input  halt, rf_rdata, mem_rdata, out_ready,
    output rf_raddr, mem_raddr, out_valid, out_kind, out_index, out_data, busy, done
  );

  // Datapath / consumer side
  modport slave (
    output halt, rf_rdata, mem_rdata, out_ready,
    input  rf_raddr, mem_raddr, out_valid, out_kind, out_index, out_data, busy, done
  );
endinterface

// File: rtl/machine_state_dumper.sv
// Streams the halted machine's register file, then a window of data memory,
// then an end marker, over a registered valid/ready output stage.
module machine_state_dumper #(
  parameter int unsigned NUM_REGS  = 32,
  parameter logic [29:0] MEM_BASE  = 30'h4000,
  parameter int unsigned MEM_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  machine_state_dumper_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_REG, S_MEM_REQ, S_MEM_CAP, S_END, S_DONE
  } state_t;

  localparam logic [5:0]  LAST_IDX = 6'(NUM_REGS - 1);
  localparam logic [30:0] MEM_CNT  = 31'(MEM_WORDS);
  localparam logic [31:0] END_DATA = 32'(NUM_REGS + MEM_WORDS);

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [30:0] m_q, m_d;
  logic        out_valid_q, out_valid_d;
  logic [1:0]  out_kind_q, out_kind_d;
  logic [29:0] out_index_q, out_index_d;
  logic [31:0] out_data_q, out_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        stage_free;
  logic [29:0] mem_idx;

  // Output register may take a new word when empty or being drained this edge.
  assign stage_free = !out_valid_q || bus.out_ready;
  // Memory word index wraps modulo 2^30.
  assign mem_idx    = MEM_BASE + m_q[29:0];

  assign bus.rf_raddr  = (state_q == S_REG) ? idx_q[4:0] : 5'd0;
  assign bus.mem_raddr = (state_q == S_MEM_REQ || state_q == S_MEM_CAP) ? mem_idx : 30'd0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_kind  = out_kind_q;
  assign bus.out_index = out_index_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  // State, counters and output stage registers; reset aborts any dump.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      m_q         <= '0;
      out_valid_q <= 1'b0;
      out_kind_q  <= '0;
      out_index_q <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      m_q         <= m_d;
      out_valid_q <= out_valid_d;
      out_kind_q  <= out_kind_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Sequencing and output-stage capture; an accepted word drops valid unless refilled.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    m_d         = m_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_kind_d  = out_kind_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    done_d      = done_q;
    case (state_q)
      S_IDLE: begin
        if (bus.halt) begin
          state_d = S_REG;
          busy_d  = 1'b1;
          idx_d   = '0;
          m_d     = '0;
        end
      end
      S_REG: begin
        if (stage_free) begin
          out_valid_d = 1'b1;
          out_kind_d  = 2'd0;
          out_index_d = {24'd0, idx_q};
          out_data_d  = bus.rf_rdata;
          idx_d       = idx_q + 6'd1;
          if (idx_q == LAST_IDX) state_d = S_MEM_REQ;
        end
      end
      S_MEM_REQ: begin
        // Address goes out this cycle; synchronous read data appears next cycle.
        state_d = S_MEM_CAP;
      end
      S_MEM_CAP: begin
        if (stage_free) begin
          out_valid_d = 1'b1;
          out_kind_d  = 2'd1;
          out_index_d = mem_idx;
          out_data_d  = bus.mem_rdata;
          m_d         = m_q + 31'd1;
          state_d     = ((m_q + 31'd1) < MEM_CNT) ? S_MEM_REQ : S_END;
        end
      end
      S_END: begin
        if (stage_free) begin
          out_valid_d = 1'b1;
          out_kind_d  = 2'd2;
          out_index_d = '0;
          out_data_d  = END_DATA;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_valid_q && bus.out_ready) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
